// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: control/status bit positions
// and the control encodings issued by the FIFO controller.
package fifo_pkg;

   localparam int CTRL_LOAD = 4;
   localparam int CTRL_READ = 3;
   localparam int CTRL_CLR  = 2;
   localparam int CTRL_RINC = 1;
   localparam int CTRL_WINC = 0;

   localparam int ST_NEQ        = 3;
   localparam int ST_FULL_EQ    = 2;
   localparam int ST_EMPTY_FWFT = 1;
   localparam int ST_EMPTY      = 0;

   typedef logic [4:0] ctrl_word_t;

   localparam ctrl_word_t ENC_CLEAR      = 5'b00100;
   localparam ctrl_word_t ENC_WRITE      = 5'b10001;
   localparam ctrl_word_t ENC_READ       = 5'b01010;
   localparam ctrl_word_t ENC_WRITE_READ = 5'b11011;
   localparam ctrl_word_t ENC_IDLE       = 5'b00000;

   // Field order matches the bit indices above.
   typedef struct packed {
      logic load;
      logic read;
      logic clr;
      logic rinc;
      logic winc;
   } ctrl_t;

endpackage

// File: rtl/fifo_datapath_ptr.sv
// fifo_ptr: wrap-bit pointer counter (MSB wrap bit + address field) with
// synchronous clear that takes priority over increment.
module fifo_ptr #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                inc_i,
   output logic [ADDR_WIDTH:0] ptr_o
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

   logic [ADDR_WIDTH:0] ptr_d;
   logic [ADDR_WIDTH:0] ptr_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + PTR_ONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_datapath.sv
// Storage and pointer datapath of the synchronous FIFO; executes the
// controller's control word. Optional `level` output: FIFO_DATAPATH_LEVEL_EN.
module fifo_datapath
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            control_signals,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [3:0]            status_signals
`ifdef FIFO_DATAPATH_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   level
`endif
);

   localparam int                  DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

   ctrl_t                 ctrl;
   logic [ADDR_WIDTH:0]   w_ptr;
   logic [ADDR_WIDTH:0]   r_ptr;
   logic [ADDR_WIDTH:0]   r_ptr_prev;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] dout_d;
   logic [DATA_WIDTH-1:0] dout_q;

   assign ctrl = ctrl_t'(control_signals);

   fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (ctrl.clr),
      .inc_i (ctrl.winc),
      .ptr_o (w_ptr)
   );

   fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (ctrl.clr),
      .inc_i (ctrl.rinc),
      .ptr_o (r_ptr)
   );

   // Clear and reset both suppress the write; memory contents survive a clear.
   assign mem_we = ctrl.load && !ctrl.clr && !rst;

   // NOTE: the storage array has no reset; only pointers and dout are initialised.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[w_ptr[ADDR_WIDTH-1:0]] <= din;
      end
   end

   // The read samples mem_q before this edge's write lands: read-before-write.
   always_comb begin
      dout_d = dout_q;
      if (ctrl.clr) begin
         dout_d = '0;
      end else if (ctrl.read) begin
         dout_d = mem_q[r_ptr[ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout       = dout_q;
   assign r_ptr_prev = r_ptr - PTR_ONE;

   always_comb begin
      status_signals                = '0;
      status_signals[ST_NEQ]        = w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH];
      status_signals[ST_FULL_EQ]    = w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0];
      status_signals[ST_EMPTY_FWFT] = r_ptr_prev == w_ptr;
      status_signals[ST_EMPTY]      = w_ptr == r_ptr;
   end

`ifdef FIFO_DATAPATH_LEVEL_EN
   assign level = w_ptr - r_ptr;
`endif

endmodule

// File: tb/tb_fifo_datapath.sv
// Scoreboard bench for fifo_datapath: stimulus queues hand-computed
// expectations, a monitor compares them one clock edge later.
module tb_fifo_datapath;
   import fifo_pkg::*;

   localparam int DW = 8;
   localparam int AW = 4;

   typedef struct {
      string      name;
      logic [7:0] dout;
      logic [3:0] status;
      logic [4:0] level;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    control_signals = ENC_IDLE;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic [3:0]    status_signals;
`ifdef FIFO_DATAPATH_LEVEL_EN
   logic [AW:0]   level;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   fifo_datapath #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .control_signals (control_signals),
      .din             (din),
      .dout            (dout),
      .status_signals  (status_signals)
`ifdef FIFO_DATAPATH_LEVEL_EN
      ,
      .level           (level)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one control word for the next edge and queue what must follow it.
   task automatic step(input string name, input logic [4:0] ctrl, input logic [7:0] d,
                       input logic [7:0] e_dout, input logic [3:0] e_status,
                       input logic [4:0] e_level);
      exp_t e;
      @(negedge clk);
      control_signals = ctrl;
      din             = d;
      e.name   = name;
      e.dout   = e_dout;
      e.status = e_status;
      e.level  = e_level;
      sb_q.push_back(e);
   endtask

   // Monitor: compare one queued expectation per clock edge, 1 time unit after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, ".dout"}, 32'(dout), 32'(e.dout));
            check({e.name, ".status"}, 32'(status_signals), 32'(e.status));
`ifdef FIFO_DATAPATH_LEVEL_EN
            check({e.name, ".level"}, 32'(level), 32'(e.level));
`endif
         end
      end
   end

   initial begin
      int budget;

      // Reset: release, run, then re-assert asynchronously in mid-cycle.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("reset.dout", 32'(dout), 32'h00);
      check("reset.status", 32'(status_signals), 32'h5);
`ifdef FIFO_DATAPATH_LEVEL_EN
      check("reset.level", 32'(level), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Fill: w_ptr 1..16, r_ptr 0.
      for (int i = 0; i < 16; i++) begin
         step("fill", ENC_WRITE, 8'(8'hA0 + i), 8'h00,
              (i == 15) ? 4'b1100 : 4'b0000, 5'(i + 1));
      end

      // Drain: r_ptr 1..16, w_ptr 16.
      for (int j = 0; j < 16; j++) begin
         step("drain", ENC_READ, 8'h00, 8'(8'hA0 + j),
              (j == 15) ? 4'b0101 : 4'b1000, 5'(15 - j));
      end
      step("drain_idle", ENC_IDLE, 8'h00, 8'hAF, 4'b0101, 5'd0);
      @(negedge clk);
      check("drain.w_ptr", 32'(dut.w_ptr), 32'd16);
      check("drain.r_ptr", 32'(dut.r_ptr), 32'd16);

      // Concurrent read+write with one word stored.
      step("conc_fill", ENC_WRITE, 8'h55, 8'hAF, 4'b0000, 5'd1);
      step("conc_rw", ENC_WRITE_READ, 8'h66, 8'h55, 4'b0000, 5'd1);
      step("conc_read", ENC_READ, 8'h00, 8'h66, 4'b0101, 5'd0);

      // Wrap: from w=r=18, advance both 14 times to 0.
      for (int k = 0; k < 14; k++) begin
         step("wrap", 5'b00011, 8'h00, 8'h66, 4'b0101, 5'd0);
      end
      step("wrap_wr", ENC_WRITE, 8'h77, 8'h66, 4'b0000, 5'd1);
      step("wrap_rd", ENC_READ, 8'h00, 8'h77, 4'b0101, 5'd0);
      // r_ptr forced one past w_ptr from empty.
      step("fwft", 5'b00010, 8'h00, 8'h77, 4'b0010, 5'd31);
      step("fwft_fix", 5'b00001, 8'h00, 8'h77, 4'b0101, 5'd0);

      // Clear with 10 words stored at addresses 2..11.
      for (int i = 0; i < 10; i++) begin
         step("clr_fill", ENC_WRITE, 8'(8'hC0 + i), 8'h77, 4'b0000, 5'(i + 1));
      end
      step("clear", ENC_CLEAR, 8'h00, 8'h00, 4'b0101, 5'd0);
      // Retained contents: address 0 holds 0x77, address 1 holds 0x66.
      step("clr_rd0", ENC_READ, 8'h00, 8'h77, 4'b0010, 5'd31);
      step("clr_rd1", ENC_READ, 8'h00, 8'h66, 4'b0000, 5'd30);

      @(negedge clk);
      control_signals = ENC_IDLE;
      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
